obstacle_scheduler: RTL and testbench

- Game-logic stage between vision_process (player lane/jump) and track_draw (obstacle array).
- Once per video frame it advances every active obstacle toward the player and retires obstacles that pass the player.
- It also checks for player collisions, spawns new obstacles from an LFSR at a fixed frame interval, and keeps a score.
- Owns the obstacle table that track_draw renders.

---
 rtl/obstacle_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_obstacle_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_scheduler.sv
// Per-frame obstacle scheduler: advances/retires obstacles, detects collisions, spawns from an LFSR, keeps score.
// Build option OBSTACLE_INVINCIBLE_EN: game_over_out stays 0 and collisions are counted on hit_count_out.
module obstacle_scheduler #(
    parameter int          NUM_SLOTS      = 10,
    parameter logic [9:0]  SPAWN_POS      = 10'd1000,
    parameter logic [9:0]  HIT_ZONE       = 10'd16,
    parameter int          SPAWN_INTERVAL = 45,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                   system_clock_in,
    input  logic                   reset_n_in,
    input  logic                   frame_tick_in,
    input  logic                   restart_in,
    input  logic [2:0]             speed_in,
    input  logic [1:0]             lane_in,
    input  logic                   jump_in,
    output logic [15*NUM_SLOTS-1:0] obstacles_out,
    output logic [15:0]            score_out,
    output logic                   game_over_out,
    output logic                   busy_out,
    output logic                   update_done_out
`ifdef OBSTACLE_INVINCIBLE_EN
    ,
    output logic [7:0]             hit_count_out
`endif
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SPAWN_INTERVAL - 1);
    // Galois feedback mask for taps 16,14,13,11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {IDLE, SCAN, SPAWN, DONE} state_t;

    typedef struct packed {
        logic [1:0] kind;
        logic [9:0] pos;
        logic [1:0] lane;
        logic       active;
    } slot_t;

    state_t           state_q, state_d;
    slot_t            slot_q [NUM_SLOTS];
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] spawn_cnt_q;
    logic [15:0]      lfsr_q;
    logic [15:0]      score_q;
    logic             game_over_q;
    logic [2:0]       speed_q;
    logic [1:0]       lane_q;
    logic             jump_q;
`ifdef OBSTACLE_INVINCIBLE_EN
    logic [7:0]       hit_cnt_q;
`endif

    logic             tick_accept;
    slot_t            cur_slot, scan_slot, spawn_slot;
    logic [9:0]       new_pos;
    logic             retire, hit;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;

    assign tick_accept = frame_tick_in && !game_over_q;

    always_ff @(posedge system_clock_in) begin
        if (!reset_n_in) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        busy_out        = (state_q != IDLE);
        update_done_out = (state_q == DONE);
        unique case (state_q)
            IDLE:    if (tick_accept) state_d = SCAN;
            SCAN:    if (idx_q == LAST_IDX) state_d = SPAWN;
            SPAWN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (restart_in) state_d = IDLE;
    end

    // Slot update for the entry under the scan index.
    always_comb begin
        cur_slot  = slot_q[idx_q];
        scan_slot = cur_slot;
        new_pos   = cur_slot.pos - {7'd0, speed_q};
        retire    = 1'b0;
        hit       = 1'b0;
        if (cur_slot.active) begin
            if (cur_slot.pos <= {7'd0, speed_q}) begin
                scan_slot = '0;
                retire    = 1'b1;
            end else begin
                scan_slot.pos = new_pos;
                hit = (cur_slot.lane == lane_q) && (new_pos < HIT_ZONE) &&
                      ((cur_slot.kind == 2'b00) || ((cur_slot.kind == 2'b01) && !jump_q));
            end
        end
    end

    // Lowest-index free slot wins: the descending walk lets lower indices overwrite.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_q[i].active) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        spawn_slot.kind   = lfsr_q[3:2];
        spawn_slot.pos    = SPAWN_POS;
        spawn_slot.lane   = (lfsr_q[1:0] == 2'b11) ? 2'b01 : lfsr_q[1:0];
        spawn_slot.active = 1'b1;
    end

    always_ff @(posedge system_clock_in) begin
        if (!reset_n_in) begin
            // NOTE: the slot table is reset because it is visible on obstacles_out and must read zero.
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
            idx_q       <= '0;
            spawn_cnt_q <= CNT_RELOAD;
            lfsr_q      <= LFSR_SEED;
            score_q     <= '0;
            game_over_q <= 1'b0;
            speed_q     <= '0;
            lane_q      <= '0;
            jump_q      <= 1'b0;
`ifdef OBSTACLE_INVINCIBLE_EN
            hit_cnt_q   <= '0;
`endif
        end else if (restart_in) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
            idx_q       <= '0;
            spawn_cnt_q <= CNT_RELOAD;
            score_q     <= '0;
            game_over_q <= 1'b0;
`ifdef OBSTACLE_INVINCIBLE_EN
            hit_cnt_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: if (tick_accept) begin
                    speed_q <= speed_in;
                    lane_q  <= lane_in;
                    jump_q  <= jump_in;
                    lfsr_q  <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
                    idx_q   <= '0;
                end
                SCAN: begin
                    slot_q[idx_q] <= scan_slot;
                    if (retire && (score_q != 16'hFFFF)) score_q <= score_q + 16'd1;
`ifdef OBSTACLE_INVINCIBLE_EN
                    if (hit && (hit_cnt_q != 8'hFF)) hit_cnt_q <= hit_cnt_q + 8'd1;
`else
                    if (hit) game_over_q <= 1'b1;
`endif
                    idx_q <= idx_q + IDX_W'(1);
                end
                SPAWN: begin
                    if (spawn_cnt_q == '0) begin
                        spawn_cnt_q <= CNT_RELOAD;
                        if (!game_over_q && free_found) slot_q[free_idx] <= spawn_slot;
                    end else begin
                        spawn_cnt_q <= spawn_cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        obstacles_out = '0;
        for (int i = 0; i < NUM_SLOTS; i++) obstacles_out[15*i +: 15] = slot_q[i];
    end

    assign score_out = score_q;
`ifdef OBSTACLE_INVINCIBLE_EN
    assign game_over_out = 1'b0;
    assign hit_count_out = hit_cnt_q;
`else
    assign game_over_out = game_over_q;
`endif

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench for obstacle_scheduler: a frame-level reference model predicts each update,
// a negedge monitor compares whenever update_done_out pulses.
`timescale 1ns/1ps
module tb_obstacle_scheduler;

    localparam int NS             = 10;
    localparam int SPAWN_POS      = 1000;
    localparam int HIT_ZONE       = 16;
    localparam int SPAWN_INTERVAL = 45;
    localparam logic [15:0] SEED  = 16'hACE1;
`ifdef OBSTACLE_INVINCIBLE_EN
    localparam bit INVINC = 1'b1;
`else
    localparam bit INVINC = 1'b0;
`endif

    logic             clk_65mhz = 1'b0;
    logic             reset_n, frame_tick, restart, jump;
    logic [2:0]       speed;
    logic [1:0]       lane;
    logic [15*NS-1:0] obstacles;
    logic [15:0]      score;
    logic             game_over, busy, update_done;
`ifdef OBSTACLE_INVINCIBLE_EN
    logic [7:0]       hit_count;
`endif

    obstacle_scheduler dut (
        .system_clock_in (clk_65mhz),
        .reset_n_in      (reset_n),
        .frame_tick_in   (frame_tick),
        .restart_in      (restart),
        .speed_in        (speed),
        .lane_in         (lane),
        .jump_in         (jump),
        .obstacles_out   (obstacles),
        .score_out       (score),
        .game_over_out   (game_over),
        .busy_out        (busy),
        .update_done_out (update_done)
`ifdef OBSTACLE_INVINCIBLE_EN
        ,
        .hit_count_out   (hit_count)
`endif
    );

    always #7.692 clk_65mhz = ~clk_65mhz;

    typedef struct {
        logic [15*NS-1:0] obs;
        logic [15:0]      score;
        logic             go;
        logic [7:0]       hits;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: one entry per slot, plain integers.
    int          m_type[NS], m_pos[NS], m_lane[NS];
    bit          m_act[NS];
    int          m_score, m_spawn, m_hits;
    bit          m_go;
    logic [15:0] m_lfsr;
    int          taps[4] = '{16, 14, 13, 11};

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] mask = '0;
        foreach (taps[k]) mask[taps[k]-1] = 1'b1;
        return v[0] ? ((v >> 1) ^ mask) : (v >> 1);
    endfunction

    function automatic void model_restart();
        for (int i = 0; i < NS; i++) begin
            m_act[i] = 0; m_type[i] = 0; m_pos[i] = 0; m_lane[i] = 0;
        end
        m_score = 0; m_go = 0; m_hits = 0;
        m_spawn = SPAWN_INTERVAL - 1;
    endfunction

    function automatic void model_reset();
        model_restart();
        m_lfsr = SEED;
    endfunction

    function automatic logic [15*NS-1:0] model_vec();
        logic [15*NS-1:0] v = '0;
        for (int i = 0; i < NS; i++)
            if (m_act[i]) v[15*i +: 15] = {2'(m_type[i]), 10'(m_pos[i]), 2'(m_lane[i]), 1'b1};
        return v;
    endfunction

    function automatic void model_frame(input int sp, input int ln, input bit jp);
        exp_t e;
        m_lfsr = lfsr_step(m_lfsr);
        for (int i = 0; i < NS; i++) begin
            if (!m_act[i]) continue;
            if (m_pos[i] <= sp) begin
                m_act[i] = 0; m_type[i] = 0; m_pos[i] = 0; m_lane[i] = 0;
                if (m_score < 65535) m_score++;
            end else begin
                m_pos[i] -= sp;
                if (m_lane[i] == ln && m_pos[i] < HIT_ZONE && (m_type[i] == 0 || (m_type[i] == 1 && !jp))) begin
                    if (INVINC) begin if (m_hits < 255) m_hits++; end
                    else m_go = 1;
                end
            end
        end
        if (m_spawn == 0) begin
            m_spawn = SPAWN_INTERVAL - 1;
            if (!m_go) begin
                for (int i = 0; i < NS; i++) begin
                    if (!m_act[i]) begin
                        m_act[i]  = 1;
                        m_pos[i]  = SPAWN_POS;
                        m_type[i] = int'(m_lfsr[3:2]);
                        m_lane[i] = (m_lfsr[1:0] == 2'd3) ? 1 : int'(m_lfsr[1:0]);
                        break;
                    end
                end
            end
        end else begin
            m_spawn--;
        end
        e.obs = model_vec(); e.score = 16'(m_score); e.go = m_go; e.hits = 8'(m_hits);
        exp_q.push_back(e);
    endfunction

    function automatic int count_active(input logic [15*NS-1:0] v);
        int c = 0;
        for (int i = 0; i < NS; i++) c += int'(v[15*i]);
        return c;
    endfunction

    function automatic int nearest_lane();
        int best = -1;
        int bp = 1 << 20;
        for (int i = 0; i < NS; i++)
            if (m_act[i] && m_pos[i] < bp) begin bp = m_pos[i]; best = i; end
        return (best < 0) ? int'($urandom_range(2, 0)) : m_lane[best];
    endfunction

    // Monitor: every update_done pulse must match the oldest prediction.
    always @(negedge clk_65mhz) begin
        exp_t e;
        if (reset_n && update_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", update_done, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("obstacles", obstacles, e.obs);
                check("score", score, e.score);
                check("game_over", game_over, e.go);
`ifdef OBSTACLE_INVINCIBLE_EN
                check("hit_count", hit_count, e.hits);
`endif
            end
        end
    end

    task automatic expect_quiet(input string name);
        int seen = 0;
        repeat (14) begin
            if (update_done === 1'b1) seen++;
            @(negedge clk_65mhz);
        end
        check({name, "_no_done"}, seen, 0);
        check({name, "_obs"}, obstacles, model_vec());
        check({name, "_score"}, score, 16'(m_score));
        check({name, "_go"}, game_over, m_go);
    endtask

    task automatic do_tick(input int sp, input int ln, input bit jp, input int extra_at);
        bit acc;
        int lat;
        @(negedge clk_65mhz);
        acc = !m_go;
        speed = 3'(sp); lane = 2'(ln); jump = jp; frame_tick = 1'b1;
        if (acc) model_frame(sp, ln, jp);
        @(negedge clk_65mhz);
        frame_tick = 1'b0;
        if (acc) begin
            check("busy_after_tick", busy, 1'b1);
            lat = 1;
            while (update_done !== 1'b1 && lat < 40) begin
                @(negedge clk_65mhz);
                lat++;
                frame_tick = (lat == extra_at);
            end
            frame_tick = 1'b0;
            check("latency", lat, 12);
        end else begin
            expect_quiet("ignored_tick");
        end
    endtask

    task automatic do_restart(input bit with_tick);
        @(negedge clk_65mhz);
        restart = 1'b1; frame_tick = with_tick; speed = 3'($urandom_range(7, 0));
        model_restart();
        @(negedge clk_65mhz);
        restart = 1'b0; frame_tick = 1'b0;
        expect_quiet("restart");
    endtask

    task automatic tick_then_restart(input int at);
        exp_t dummy;
        @(negedge clk_65mhz);
        speed = 3'd3; lane = 2'd0; jump = 1'b0; frame_tick = 1'b1;
        model_frame(3, 0, 0);
        @(negedge clk_65mhz);
        frame_tick = 1'b0;
        repeat (at - 1) @(negedge clk_65mhz);
        restart = 1'b1;
        @(negedge clk_65mhz);
        restart = 1'b0;
        dummy = exp_q.pop_back();
        model_restart();
        expect_quiet("mid_restart");
    endtask

    // Restart, optionally pad LFSR steps so the next spawn has the wanted type, then spawn into slot 0.
    task automatic fresh_obstacle(input int want, output int ln);
        logic [15:0] l;
        int pad = 0;
        bit found = 0;
        do_restart(1'b0);
        if (want >= 0) begin
            for (int k = 0; k < 64 && !found; k++) begin
                l = m_lfsr;
                repeat (k + SPAWN_INTERVAL) l = lfsr_step(l);
                if (int'(l[3:2]) == want) begin pad = k; found = 1; end
            end
            repeat (pad) do_tick(0, 0, 1'b0, 0);
            do_restart(1'b0);
        end
        repeat (SPAWN_INTERVAL) do_tick(0, 0, 1'b0, 0);
        if (want >= 0) check("spawn_type", obstacles[14:13], 2'(want));
        ln = m_lane[0];
    endtask

    task automatic drive_to(input int target, input int ln, input bit jp);
        int s;
        int guard = 0;
        while (m_act[0] && !m_go && m_pos[0] > target && guard < 200) begin
            s = m_pos[0] - target;
            if (s > 7) s = 7;
            do_tick(s, ln, jp, 0);
            guard++;
        end
    endtask

    initial begin
        #1_400_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        int L;
        logic [15*NS-1:0] snap;
        exp_t dummy;
        reset_n = 1'b0; frame_tick = 1'b0; restart = 1'b0;
        speed = '0; lane = '0; jump = 1'b0;
        model_reset();
        repeat (5) @(negedge clk_65mhz);
        reset_n = 1'b1;
        check("rst_obstacles", obstacles, '0);
        check("rst_score", score, 16'd0);
        check("rst_game_over", game_over, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", update_done, 1'b0);

        // Three empty frames, then the first spawn on frame 45.
        repeat (3) do_tick(2, $urandom_range(2, 0), 1'b0, 0);
        check("init_obstacles", obstacles, '0);
        check("init_score", score, 16'd0);
        repeat (SPAWN_INTERVAL - 3) do_tick(2, $urandom_range(2, 0), 1'b0, 0);
        check("first_spawn_count", count_active(obstacles), 1);
        check("first_spawn_pos", obstacles[12:3], 10'd1000);
        check("first_spawn_lane_ok", obstacles[2:1] <= 2'd2, 1'b1);

        // Movement: 10 frames at speed 7 in another lane.
        L = m_lane[0];
        repeat (10) do_tick(7, (L + 1) % 3, 1'b0, 0);
        check("move_pos", obstacles[12:3], 10'd930);
        check("move_go", game_over, 1'b0);

        // Retirement at position == speed.
        fresh_obstacle(-1, L);
        drive_to(5, (L + 1) % 3, 1'b0);
        do_tick(5, (L + 1) % 3, 1'b0, 0);
        check("retire_slot", obstacles[14:0], 15'd0);
        check("retire_score", score, 16'd1);

        // Position one above speed stays active.
        fresh_obstacle(-1, L);
        drive_to(6, (L + 1) % 3, 1'b0);
        do_tick(5, (L + 1) % 3, 1'b0, 0);
        check("near_pos", obstacles[12:3], 10'd1);
        check("near_active", obstacles[0], 1'b1);

        // Wall hit even when jumping; afterwards frames are ignored.
        fresh_obstacle(0, L);
        drive_to(20, L, 1'b1);
        do_tick(7, L, 1'b1, 0);
        check("wall_go", game_over, !INVINC);
        check("wall_pos", obstacles[12:3], 10'd13);
        do_tick(3, L, 1'b1, 0);
        do_tick(3, L, 1'b1, 0);

        // Barrier: cleared by a jump, hit without one.
        fresh_obstacle(1, L);
        drive_to(20, L, 1'b1);
        do_tick(7, L, 1'b1, 0);
        check("barrier_jump_go", game_over, 1'b0);
        do_tick(7, L, 1'b0, 0);
        check("barrier_ground_go", game_over, !INVINC);

        // Fill all slots, then one more spawn attempt must be dropped.
        do_restart(1'b1);
        repeat (NS * SPAWN_INTERVAL) do_tick(0, 0, 1'b0, 0);
        check("full_count", count_active(obstacles), NS);
        snap = model_vec();
        repeat (SPAWN_INTERVAL) do_tick(0, 0, 1'b0, 0);
        check("full_no_change", obstacles, snap);

        // Ticks while busy are dropped; restart mid-update kills the update.
        do_tick(4, 0, 1'b0, 4);
        do_tick(2, 1, 1'b1, 7);
        tick_then_restart(6);

        // Randomised play.
        repeat (800) begin
            if (m_go) begin
                if ($urandom_range(1, 0) == 1) do_tick($urandom_range(7, 0), 0, 1'b0, 0);
                do_restart(1'($urandom_range(1, 0)));
            end else begin
                L = ($urandom_range(9, 0) < 7) ? nearest_lane() : int'($urandom_range(2, 0));
                do_tick($urandom_range(7, 0), L, 1'($urandom_range(1, 0)), 0);
            end
            if ($urandom_range(99, 0) == 0) do_restart(1'($urandom_range(1, 0)));
        end

        // Reset mid-update: state cleared and LFSR reseeded.
        if (m_go) do_restart(1'b0);
        @(negedge clk_65mhz);
        speed = 3'd1; lane = 2'd2; jump = 1'b0; frame_tick = 1'b1;
        model_frame(1, 2, 1'b0);
        @(negedge clk_65mhz);
        frame_tick = 1'b0;
        repeat (4) @(negedge clk_65mhz);
        reset_n = 1'b0;
        @(negedge clk_65mhz);
        @(negedge clk_65mhz);
        reset_n = 1'b1;
        dummy = exp_q.pop_back();
        model_reset();
        check("rst_mid_busy", busy, 1'b0);
        expect_quiet("rst_mid");
        repeat (SPAWN_INTERVAL) do_tick($urandom_range(7, 0), 0, 1'b0, 0);

        repeat (20) @(negedge clk_65mhz);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
